// File: rtl/mmc1_pkg.sv
// Shared encodings for the MMC1 bank controller: register selects, PRG modes,
// mirroring codes and the control register layout.
package mmc1_pkg;

  localparam int SHIFT_LEN = 5;

  typedef enum logic [1:0] {
    SEL_CTRL = 2'd0,
    SEL_CHR0 = 2'd1,
    SEL_CHR1 = 2'd2,
    SEL_PRG  = 2'd3
  } reg_sel_e;

  typedef enum logic [1:0] {
    PRG_MODE_32K_A  = 2'd0,
    PRG_MODE_32K_B  = 2'd1,
    PRG_MODE_FIX_LO = 2'd2,
    PRG_MODE_FIX_HI = 2'd3
  } prg_mode_e;

  typedef enum logic [1:0] {
    MIRROR_ONE_LO = 2'd0,
    MIRROR_ONE_HI = 2'd1,
    MIRROR_VERT   = 2'd2,
    MIRROR_HORIZ  = 2'd3
  } mirror_e;

  typedef struct packed {
    logic      chr_4k;
    prg_mode_e prg_mode;
    mirror_e   mirror;
  } ctrl_t;

  localparam logic [4:0] CTRL_RESET = 5'h0C;

  function automatic ctrl_t ctrl_from_bits(input logic [4:0] v);
    return ctrl_t'(v);
  endfunction

endpackage

// File: rtl/mmc1_shift_loader.sv
// Serial write capture: consecutive-write filter, 5-bit shift register,
// bit count and reset-bit handling. Emits one-cycle load/reset strobes.
module mmc1_shift_loader
  import mmc1_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ce,
  input  logic       i_rnw,
  input  logic [7:0] i_data,
  input  logic [1:0] i_sel,
  output logic       o_load,
  output logic [4:0] o_value,
  output reg_sel_e   o_sel,
  output logic       o_reset_hit,
  output logic [2:0] o_count
);

  // Strobe semantics: o_load and o_reset_hit are combinational and valid only
  // in the cycle whose closing edge also commits the write; the consumer has no
  // back-pressure and must capture on that same edge.

  logic       prev_wr_q, prev_wr_d;
  logic [4:0] shift_q, shift_d;
  logic [2:0] count_q, count_d;
  logic       wr;
  logic       accept;
  logic [4:0] next_value;
  logic       load;
  logic       reset_hit;
  logic       unused_data;

  assign wr          = i_ce & ~i_rnw;
  assign accept      = wr & ~prev_wr_q;
  assign next_value  = {i_data[0], shift_q[4:1]};
  assign unused_data = ^i_data[6:1];

  always_comb begin
    prev_wr_d = wr;
    shift_d   = shift_q;
    count_d   = count_q;
    load      = 1'b0;
    reset_hit = 1'b0;
    if (accept) begin
      if (i_data[7]) begin
        shift_d   = '0;
        count_d   = '0;
        reset_hit = 1'b1;
      end else if (count_q == 3'(SHIFT_LEN - 1)) begin
        // Fifth bit completes the value; the loader empties on the same edge.
        shift_d = '0;
        count_d = '0;
        load    = 1'b1;
      end else begin
        shift_d = next_value;
        count_d = count_q + 3'd1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      prev_wr_q <= 1'b0;
      shift_q   <= '0;
      count_q   <= '0;
    end else begin
      prev_wr_q <= prev_wr_d;
      shift_q   <= shift_d;
      count_q   <= count_d;
    end
  end

  assign o_load      = load;
  assign o_value     = next_value;
  assign o_sel       = reg_sel_e'(i_sel);
  assign o_reset_hit = reset_hit;
  assign o_count     = count_q;

endmodule

// File: rtl/mmc1_bank_controller.sv
// MMC1 bank controller: holds control/chr0/chr1/prg registers loaded through
// the serial shift loader and decodes CPU/PPU addresses into ROM indices.
module mmc1_bank_controller
  import mmc1_pkg::*;
#(
  parameter int PRG_BANK_BITS = 4,
  parameter int CHR_BANK_BITS = 5
) (
  input  logic                       i_clk_cpu,
  input  logic                       i_rst,
  input  logic                       i_ce,
  input  logic                       i_rnw,
  input  logic [15:0]                i_addr,
  input  logic [7:0]                 i_data,
  input  logic [12:0]                i_ppu_addr,
  output logic [PRG_BANK_BITS+13:0]  o_prg_addr,
  output logic [CHR_BANK_BITS+11:0]  o_chr_addr,
  output logic [1:0]                 o_mirror,
  output logic                       o_wram_en,
  output logic [2:0]                 o_shift_cnt
);

  logic       load;
  logic [4:0] load_value;
  reg_sel_e   load_sel;
  logic       reset_hit;
  logic [2:0] shift_cnt;

  mmc1_shift_loader u_loader (
    .i_clk       (i_clk_cpu),
    .i_rst       (i_rst),
    .i_ce        (i_ce),
    .i_rnw       (i_rnw),
    .i_data      (i_data),
    .i_sel       (i_addr[14:13]),
    .o_load      (load),
    .o_value     (load_value),
    .o_sel       (load_sel),
    .o_reset_hit (reset_hit),
    .o_count     (shift_cnt)
  );

  ctrl_t      control_q, control_d;
  logic [4:0] chr0_q, chr0_d;
  logic [4:0] chr1_q, chr1_d;
  logic [4:0] prg_q, prg_d;

  always_comb begin
    control_d = control_q;
    chr0_d    = chr0_q;
    chr1_d    = chr1_q;
    prg_d     = prg_q;
    // Reset-bit writes force the fixed-last-bank PRG mode and touch nothing else.
    if (reset_hit) begin
      control_d.prg_mode = PRG_MODE_FIX_HI;
    end
    if (load) begin
      unique case (load_sel)
        SEL_CTRL: control_d = ctrl_from_bits(load_value);
        SEL_CHR0: chr0_d    = load_value;
        SEL_CHR1: chr1_d    = load_value;
        SEL_PRG:  prg_d     = load_value;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge i_clk_cpu or posedge i_rst) begin
    if (i_rst) begin
      control_q <= ctrl_from_bits(CTRL_RESET);
      chr0_q    <= '0;
      chr1_q    <= '0;
      prg_q     <= '0;
    end else begin
      control_q <= control_d;
      chr0_q    <= chr0_d;
      chr1_q    <= chr1_d;
      prg_q     <= prg_d;
    end
  end

  logic                     prg_hi_half;
  logic [3:0]               prg_bank4;
  logic [PRG_BANK_BITS-1:0] prg_bank;
  logic [4:0]               chr_bank5;
  logic [CHR_BANK_BITS-1:0] chr_bank;
  logic                     unused_addr_msb;

  assign prg_hi_half     = i_addr[14];
  assign unused_addr_msb = i_addr[15];

  always_comb begin
    prg_bank4 = '0;
    prg_bank  = '0;
    unique case (control_q.prg_mode)
      PRG_MODE_32K_A, PRG_MODE_32K_B: begin
        prg_bank4 = {prg_q[3:1], prg_hi_half};
        prg_bank  = PRG_BANK_BITS'(prg_bank4);
      end
      PRG_MODE_FIX_LO: begin
        prg_bank4 = prg_hi_half ? prg_q[3:0] : 4'd0;
        prg_bank  = PRG_BANK_BITS'(prg_bank4);
      end
      PRG_MODE_FIX_HI: begin
        prg_bank4 = prg_q[3:0];
        // Upper window always hits the last bank of the configured ROM size.
        prg_bank  = prg_hi_half ? '1 : PRG_BANK_BITS'(prg_bank4);
      end
      default: ;
    endcase
  end

  always_comb begin
    chr_bank5 = '0;
    if (control_q.chr_4k) begin
      chr_bank5 = i_ppu_addr[12] ? chr1_q : chr0_q;
    end else begin
      chr_bank5 = {chr0_q[4:1], i_ppu_addr[12]};
    end
    chr_bank = CHR_BANK_BITS'(chr_bank5);
  end

  assign o_prg_addr  = {prg_bank, i_addr[13:0]};
  assign o_chr_addr  = {chr_bank, i_ppu_addr[11:0]};
  assign o_mirror    = control_q.mirror;
  assign o_wram_en   = ~prg_q[4];
  assign o_shift_cnt = shift_cnt;

endmodule

// File: tb/tb_mmc1_bank_controller.sv
// Bench for mmc1_bank_controller: directed scenarios with literal expectations
// plus randomized bus traffic checked every cycle against a behavioural model.
module tb_mmc1_bank_controller;

  localparam int PB = 4;
  localparam int CB = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_ce;
  logic          i_rnw;
  logic [15:0]   i_addr;
  logic [7:0]    i_data;
  logic [12:0]   i_ppu_addr;
  logic [PB+13:0] o_prg_addr;
  logic [CB+11:0] o_chr_addr;
  logic [1:0]    o_mirror;
  logic          o_wram_en;
  logic [2:0]    o_shift_cnt;

  always #5 clk = ~clk;

  mmc1_bank_controller #(.PRG_BANK_BITS(PB), .CHR_BANK_BITS(CB)) dut (
    .i_clk_cpu   (clk),
    .i_rst       (rst),
    .i_ce        (i_ce),
    .i_rnw       (i_rnw),
    .i_addr      (i_addr),
    .i_data      (i_data),
    .i_ppu_addr  (i_ppu_addr),
    .o_prg_addr  (o_prg_addr),
    .o_chr_addr  (o_chr_addr),
    .o_mirror    (o_mirror),
    .o_wram_en   (o_wram_en),
    .o_shift_cnt (o_shift_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Behavioural model: registers as integers, loader as a queue of bits.
  int m_ctrl, m_chr0, m_chr1, m_prg;
  int bits_q[$];
  bit m_prev;
  bit m_wr;
  int m_val;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ctrl = 12; m_chr0 = 0; m_chr1 = 0; m_prg = 0;
      bits_q.delete();
      m_prev = 1'b0;
    end else begin
      m_wr = (i_ce === 1'b1) && (i_rnw === 1'b0);
      if (m_wr && !m_prev) begin
        if (i_data[7]) begin
          bits_q.delete();
          m_ctrl = m_ctrl | 12;
        end else begin
          bits_q.push_back(int'(i_data[0]));
          if (bits_q.size() == 5) begin
            m_val = 0;
            for (int i = 0; i < 5; i++) m_val += bits_q[i] << i;
            case (i_addr[14:13])
              2'd0: m_ctrl = m_val;
              2'd1: m_chr0 = m_val;
              2'd2: m_chr1 = m_val;
              default: m_prg = m_val;
            endcase
            bits_q.delete();
          end
        end
      end
      m_prev = m_wr;
    end
  end

  function automatic int exp_prg(input logic [15:0] a);
    int mode, p, bank, hi;
    mode = (m_ctrl >> 2) & 3;
    p    = m_prg & 15;
    hi   = a[14] ? 1 : 0;
    case (mode)
      0, 1:    bank = (p & 14) + hi;
      2:       bank = hi ? p : 0;
      default: bank = hi ? 15 : p;
    endcase
    return bank * 16384 + int'(a & 16'h3FFF);
  endfunction

  function automatic int exp_chr(input logic [12:0] pa);
    if (((m_ctrl >> 4) & 1) == 0) return (m_chr0 >> 1) * 8192 + int'(pa);
    return (pa[12] ? m_chr1 : m_chr0) * 4096 + int'(pa & 13'h0FFF);
  endfunction

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("prg_addr", 32'(o_prg_addr), 32'(exp_prg(i_addr)));
      check("chr_addr", 32'(o_chr_addr), 32'(exp_chr(i_ppu_addr)));
      check("mirror", 32'(o_mirror), 32'(m_ctrl & 3));
      check("wram_en", 32'(o_wram_en), 32'((m_prg >> 4) & 1 ? 0 : 1));
      check("shift_cnt", 32'(o_shift_cnt), 32'(bits_q.size()));
    end
  end

  task automatic cyc(input logic ce, input logic rnw, input logic [15:0] a, input logic [7:0] d);
    i_ce = ce; i_rnw = rnw; i_addr = a; i_data = d;
    @(posedge clk); #1;
  endtask

  task automatic sw(input logic [15:0] a, input logic b);
    cyc(1'b1, 1'b0, a, {7'd0, b});
    cyc(1'b0, 1'b1, a, 8'h00);
  endtask

  task automatic load5(input logic [15:0] a, input logic [4:0] v);
    for (int i = 0; i < 5; i++) sw(a, v[i]);
  endtask

  task automatic peek(input logic [15:0] a);
    i_ce = 1'b0; i_rnw = 1'b1; i_addr = a; i_data = 8'h00;
    @(negedge clk); #1;
  endtask

  task automatic realign();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b0; i_ce = 1'b0; i_rnw = 1'b1; i_addr = 16'h8000; i_data = 8'h00; i_ppu_addr = 13'h0000;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cmp_en = 1'b1;

    peek(16'h8000);
    check("rst_prg_8000", 32'(o_prg_addr), 32'h00000);
    check("rst_wram", 32'(o_wram_en), 32'd1);
    check("rst_mirror", 32'(o_mirror), 32'd0);
    check("rst_cnt", 32'(o_shift_cnt), 32'd0);
    realign();
    peek(16'hFFFC);
    check("rst_prg_fffc", 32'(o_prg_addr), 32'h3FFFC);
    realign();

    load5(16'hE000, 5'b00101);
    peek(16'h8123);
    check("prg5_8123", 32'(o_prg_addr), 32'h14123);
    realign();
    peek(16'hC000);
    check("prg5_c000", 32'(o_prg_addr), 32'h3C000);
    realign();

    sw(16'hA000, 1'b1); sw(16'hA000, 1'b1); sw(16'hA000, 1'b1);
    peek(16'hA000);
    check("three_bits_cnt", 32'(o_shift_cnt), 32'd3);
    realign();
    cyc(1'b1, 1'b0, 16'hA000, 8'h80);
    cyc(1'b0, 1'b1, 16'hA000, 8'h00);
    peek(16'hC000);
    check("resetbit_cnt", 32'(o_shift_cnt), 32'd0);
    check("resetbit_mode3", 32'(o_prg_addr), 32'h3C000);
    realign();
    load5(16'hA000, 5'h0A);

    cyc(1'b1, 1'b0, 16'hE000, 8'h01);
    cyc(1'b1, 1'b0, 16'hE000, 8'h00);
    cyc(1'b0, 1'b1, 16'hE000, 8'h00);
    peek(16'hE000);
    check("b2b_cnt", 32'(o_shift_cnt), 32'd1);
    realign();
    sw(16'hE000, 1'b1); sw(16'hE000, 1'b0); sw(16'hE000, 1'b0); sw(16'hE000, 1'b1);
    peek(16'h8000);
    check("prg13_wram_off", 32'(o_wram_en), 32'd0);
    check("prg13_8000", 32'(o_prg_addr), 32'h0C000);
    realign();

    load5(16'h8000, 5'h12);
    load5(16'hC000, 5'h03);
    i_ppu_addr = 13'h1456;
    peek(16'h8000);
    check("ctrl12_mirror", 32'(o_mirror), 32'd2);
    check("ctrl12_chr", 32'(o_chr_addr), 32'h03456);
    check("ctrl12_prg32k", 32'(o_prg_addr), 32'h08000);
    realign();

    sw(16'hE000, 1'b1); sw(16'hE000, 1'b0); sw(16'hE000, 1'b1);
    i_addr = 16'h8000;
    #1 rst = 1'b1;
    #1;
    check("async_cnt", 32'(o_shift_cnt), 32'd0);
    check("async_mirror", 32'(o_mirror), 32'd0);
    check("async_wram", 32'(o_wram_en), 32'd1);
    check("async_prg", 32'(o_prg_addr), 32'h00000);
    check("async_chr", 32'(o_chr_addr), 32'h01456);
    #1 rst = 1'b0;
    realign();
    sw(16'hE000, 1'b1);
    peek(16'hE000);
    check("post_rst_first_write", 32'(o_shift_cnt), 32'd1);
    realign();

    for (int n = 0; n < 3000; n++) begin
      logic [7:0] d;
      d = {($urandom_range(0, 15) == 0), 6'($urandom), 1'($urandom)};
      i_ppu_addr = 13'($urandom);
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, {1'b1, 15'($urandom)}, d);
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
